csr_uart_tx: RTL and testbench
==============================

Name: csr_uart_tx

Overview:
- CSR-mapped UART transmitter for the RudolV pipeline.
- Replaces the simulation-only character sink at CSR 0xBC0 with real hardware: a small byte FIFO, a baud divider and an 8N1 serialiser.
- Sits on the shared CSR bus beside the ID, counter, pin and timer CSR blocks. Its rdata/valid are ORed into the pipeline's csr_rdata/csr_valid.

Parameters:
- BASE_ADDR, 12'hBC0, CSR address of the UART data/status register.
- CLK_DIV, 104, clock cycles per bit (clk frequency / baud). Legal range 2..65535.
- DEPTH, 8, FIFO entries. Must be a power of two, 2..64.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; asynchronous assert, active-low.
- read  in  1  CSR read request, valid with addr.
- modify  in  3  CSR modify code, one cycle after addr: 0 none, 1 write, 2 set, 3 clear, others none.
- wdata  in  32  CSR write data, valid with modify.
- addr  in  12  CSR address.
- rdata  out  32  status word; 0 when not selected.
- valid  out  1  this block claims the CSR access.
- tx  out  1  serial output, idle high.
- irq  out  1  TX-empty interrupt (CSR_UART_IRQ_EN only; otherwise tied 0).

Behaviour:
- Reset values (async, rstn=0):
  - tx=1, rdata=0, valid=0, irq=0.
  - FIFO empty, overflow=0, FSM IDLE, divider=0, bit counter=0.
- Address phase (cycle N):
  - q_sel <= (addr==BASE_ADDR).
  - q_rd <= read & (addr==BASE_ADDR).
- Response phase (cycle N+1):
  - valid = q_rd.
  - rdata = q_rd ? status : 0.
- Status word:
  - [7:0] FIFO fill level.
  - [8] full.
  - [9] overflow (sticky).
  - [10] busy (FSM != IDLE or FIFO non-empty).
  - [31:11] 0.
- Enqueue: modify==1 & q_sel pushes wdata[7:0]; entry visible next cycle.
- Full FIFO:
  - Full is evaluated before any same-cycle pop.
  - A write while full is dropped and sets overflow.
- Overflow clear: modify==3 & q_sel & wdata[9] clears overflow. Clear wins over a same-cycle set.
- modify==2 has no effect on data or flags.
- FIFO: read/write pointers of log2(DEPTH)+1 bits, wrap-around by natural overflow.
  - empty = pointers equal.
  - full = MSBs differ and the rest is equal.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: if FIFO non-empty, pop into shift register, divider<=0, go to START. tx low from the next cycle.
  - START: tx=0 for CLK_DIV cycles, then go to DATA with bit counter=0.
  - DATA: tx=shift[0], LSB first, each bit CLK_DIV cycles. After bit 7 go to STOP.
  - STOP: tx=1 for CLK_DIV cycles, then go to IDLE. A queued byte pops in the IDLE cycle, so the inter-frame gap is exactly 1 cycle.
- Latency: write modify in cycle N, entry in FIFO at N+1, pop at end of N+1, tx falls at start of N+2.
- Frame length: 10*CLK_DIV cycles.
- Simultaneous push and pop on a non-full FIFO: both occur; fill level unchanged.
- Reset mid-frame: tx goes high immediately, frame aborted, FIFO flushed.
- Divider is 16 bits; it compares against CLK_DIV-1 and restarts at 0.

Optional Feature:
- Macro CSR_UART_IRQ_EN.
- Defined:
  - irq is registered; irq=1 while FIFO empty, FSM IDLE and status bit 11 (irq enable) is set.
  - Bit 11 is set by modify==2 & wdata[11]; cleared by modify==3 & wdata[11] or modify==1 with wdata[11]=0.
  - rdata[11] reflects the enable.
- Undefined: irq=0 constant, rdata[11]=0, enable logic absent.

Decomposition:
- Shared package: CSR modify codes (CSR_MOD_NONE/WRITE/SET/CLEAR), CSR_UART address, status bit positions, UART FSM state enum.
- Sub-module sync_fifo: DEPTH, WIDTH=8; push/pop/full/empty/level; async active-low reset.
- Serialiser FSM and CSR decode stay in csr_uart_tx.

Test Plan:
- Reset, then idle 50 cycles -> tx=1, rdata=0, valid=0, irq=0.
- Write 0x55 with CLK_DIV=4 -> tx falls 2 cycles after modify. Line shows 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles. Stop high 4 cycles, busy then 0.
- Write 9 bytes back-to-back with DEPTH=8, CLK_DIV=100 -> first byte pops, 8 bytes queue. Status read gives full=1 then level 8; no byte is dropped. A 10th write gives overflow=1. A clear with wdata=0x200 gives overflow=0.
- Read at BASE_ADDR+1 -> valid=0, rdata=0. Read at BASE_ADDR with FIFO holding 3 -> valid=1 next cycle, rdata=0x403.
- Deassert rstn in DATA bit 3 -> tx=1 in the same cycle, level=0 after release, no residual frame.
- With CSR_UART_IRQ_EN: set bit 11, write 0xA5 -> irq=0 during the frame, irq=1 one cycle after STOP ends. Clear bit 11 -> irq=0.

Source files
------------

// File: rtl/csr_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Package : csr_uart_tx_pkg
// Brief   : Shared CSR modify codes, UART register address, status bit
//           positions and serialiser state encoding for csr_uart_tx.
// Rev     : 1.0 - initial release
// ============================================================================
package csr_uart_tx_pkg;

    localparam logic [2:0] CSR_MOD_NONE  = 3'd0;
    localparam logic [2:0] CSR_MOD_WRITE = 3'd1;
    localparam logic [2:0] CSR_MOD_SET   = 3'd2;
    localparam logic [2:0] CSR_MOD_CLEAR = 3'd3;

    localparam logic [11:0] CSR_UART = 12'hBC0;

    localparam int STAT_FULL   = 8;
    localparam int STAT_OVF    = 9;
    localparam int STAT_BUSY   = 10;
    localparam int STAT_IRQ_EN = 11;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

endpackage : csr_uart_tx_pkg
`default_nettype wire

// File: rtl/csr_uart_tx_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : csr_uart_tx_sync_fifo
// Brief  : Single-clock FIFO with extra-MSB pointers; full is evaluated
//          before a same-cycle pop, so a push into a full FIFO is refused.
// Rev    : 1.0 - initial release
// ============================================================================
module csr_uart_tx_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int c_aw = $clog2(DEPTH);

    logic [c_aw:0]      r_wr_ptr;
    logic [c_aw:0]      r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_do_push;
    logic               w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                       (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign o_dout    = r_mem[r_rd_ptr[c_aw-1:0]];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_aw-1:0]] <= i_din;
    end

endmodule : csr_uart_tx_sync_fifo
`default_nettype wire

// File: rtl/csr_uart_tx.sv
`default_nettype none
// ============================================================================
// Module : csr_uart_tx
// Brief  : CSR-mapped 8N1 UART transmitter with byte FIFO and baud divider.
//          Optional macro CSR_UART_IRQ_EN adds a TX-empty interrupt.
// Rev    : 1.0 - initial release
// ============================================================================
module csr_uart_tx
    import csr_uart_tx_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR = CSR_UART,
    parameter int          CLK_DIV   = 104,
    parameter int          DEPTH     = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        read,
    input  logic [2:0]  modify,
    input  logic [31:0] wdata,
    input  logic [11:0] addr,
    output logic [31:0] rdata,
    output logic        valid,
    output logic        tx,
    output logic        irq
);

    localparam int          c_lvl_w    = $clog2(DEPTH) + 1;
    localparam logic [15:0] c_div_last = 16'(CLK_DIV - 1);

    logic               r_sel;
    logic               r_rd;
    logic               r_ovf;
    uart_state_e        r_state;
    uart_state_e        w_state_nxt;
    logic [15:0]        r_div;
    logic [15:0]        w_div_nxt;
    logic [2:0]         r_bit;
    logic [2:0]         w_bit_nxt;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_nxt;
    logic               w_tx;
    logic               w_pop;
    logic               w_wr;
    logic               w_clr;
    logic               w_push;
    logic               w_full;
    logic               w_empty;
    logic               w_busy;
    logic               w_irq_en;
    logic [7:0]         w_fifo_dout;
    logic [c_lvl_w-1:0] w_level;
    logic [31:0]        w_status;
    logic               w_unused_wdata;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sel <= 1'b0;
            r_rd  <= 1'b0;
        end else begin
            r_sel <= (addr == BASE_ADDR);
            r_rd  <= read & (addr == BASE_ADDR);
        end
    end

    assign w_wr   = r_sel & (modify == CSR_MOD_WRITE);
    assign w_clr  = r_sel & (modify == CSR_MOD_CLEAR);
    assign w_push = w_wr & ~w_full;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ovf <= 1'b0;
        end else if (w_clr & wdata[STAT_OVF]) begin
            r_ovf <= 1'b0;
        end else if (w_wr & w_full) begin
            r_ovf <= 1'b1;
        end
    end

    csr_uart_tx_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_din   (wdata[7:0]),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= UART_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Every bit period ends when the divider reaches CLK_DIV-1; IDLE pops
    // immediately so back-to-back frames are separated by one idle cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
        w_tx        = 1'b1;
        case (r_state)
            UART_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_fifo_dout;
                    w_div_nxt   = '0;
                    w_state_nxt = UART_START;
                end
            end
            UART_START: begin
                w_tx = 1'b0;
                if (r_div == c_div_last) begin
                    w_div_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = UART_DATA;
                end else begin
                    w_div_nxt = r_div + 16'd1;
                end
            end
            UART_DATA: begin
                w_tx = r_shift[0];
                if (r_div == c_div_last) begin
                    w_div_nxt = '0;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = UART_STOP;
                    end else begin
                        w_bit_nxt   = r_bit + 3'd1;
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                    end
                end else begin
                    w_div_nxt = r_div + 16'd1;
                end
            end
            UART_STOP: begin
                if (r_div == c_div_last) begin
                    w_div_nxt   = '0;
                    w_state_nxt = UART_IDLE;
                end else begin
                    w_div_nxt = r_div + 16'd1;
                end
            end
            default: begin
                w_state_nxt = UART_IDLE;
            end
        endcase
    end

    assign tx     = w_tx;
    assign w_busy = (r_state != UART_IDLE) | ~w_empty;

`ifdef CSR_UART_IRQ_EN
    logic r_irq_en;
    logic r_irq;
    logic w_set;

    assign w_set = r_sel & (modify == CSR_MOD_SET);

    // A plain write rewrites the whole register, so bit 11 low disables.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if ((w_clr & wdata[STAT_IRQ_EN]) | (w_wr & ~wdata[STAT_IRQ_EN])) begin
                r_irq_en <= 1'b0;
            end else if (w_set & wdata[STAT_IRQ_EN]) begin
                r_irq_en <= 1'b1;
            end
            r_irq <= w_empty & (r_state == UART_IDLE) & r_irq_en;
        end
    end

    assign irq            = r_irq;
    assign w_irq_en       = r_irq_en;
    assign w_unused_wdata = ^{wdata[31:12], wdata[10], wdata[8]};
`else
    assign irq            = 1'b0;
    assign w_irq_en       = 1'b0;
    assign w_unused_wdata = ^{wdata[31:10], wdata[8]};
`endif

    always_comb begin
        w_status              = '0;
        w_status[7:0]         = 8'(w_level);
        w_status[STAT_FULL]   = w_full;
        w_status[STAT_OVF]    = r_ovf;
        w_status[STAT_BUSY]   = w_busy;
        w_status[STAT_IRQ_EN] = w_irq_en;
    end

    assign valid = r_rd;
    assign rdata = r_rd ? w_status : 32'd0;

endmodule : csr_uart_tx
`default_nettype wire

// File: tb/tb_csr_uart_tx.sv
`default_nettype none
// ============================================================================
// Module : tb_csr_uart_tx
// Brief  : Directed self-checking bench for csr_uart_tx (CLK_DIV=4, DEPTH=8).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_csr_uart_tx;

    localparam logic [11:0] c_base = 12'hBC0;
    localparam int          c_div  = 4;
    localparam int          c_mid  = c_div / 2;

    logic        clk;
    logic        rstn;
    logic        read;
    logic [2:0]  modify;
    logic [31:0] wdata;
    logic [11:0] addr;
    logic [31:0] rdata;
    logic        valid;
    logic        tx;
    logic        irq;

    int          errors;
    int          checks;
    logic [31:0] rd;
    logic        v;

    logic [7:0]  rx_q [$];
    logic        mon_act;
    int          mon_cnt;
    logic [7:0]  mon_sh;
    int          frame_err;

    csr_uart_tx #(
        .BASE_ADDR (c_base),
        .CLK_DIV   (c_div),
        .DEPTH     (8)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .read   (read),
        .modify (modify),
        .wdata  (wdata),
        .addr   (addr),
        .rdata  (rdata),
        .valid  (valid),
        .tx     (tx),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line receiver: samples mid-bit and queues each completed byte.
    always @(negedge clk) begin
        if (!rstn) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (tx === 1'b0) begin
                mon_act = 1'b1;
                mon_cnt = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == c_mid + 9 * c_div) begin
                if (tx !== 1'b1) frame_err++;
                rx_q.push_back(mon_sh);
                mon_act = 1'b0;
            end else if (mon_cnt >= c_mid + c_div && (mon_cnt % c_div) == c_mid) begin
                mon_sh = {tx, mon_sh[7:1]};
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Address phase, then modify/wdata phase; returns the response sampled
    // in the modify cycle. modify stays driven until the next bus action.
    task automatic csr(input logic [11:0] a, input logic r, input logic [2:0] mod,
                       input logic [31:0] wd, output logic [31:0] rv, output logic vv);
        @(negedge clk);
        addr = a; read = r; modify = 3'd0; wdata = 32'd0;
        @(negedge clk);
        vv = valid; rv = rdata;
        addr = 12'd0; read = 1'b0; modify = mod; wdata = wd;
    endtask

    task automatic idle();
        @(negedge clk);
        addr = 12'd0; read = 1'b0; modify = 3'd0; wdata = 32'd0;
    endtask

    task automatic expect_rx(input string tag, input logic [7:0] exp);
        logic [31:0] obs;
        if (rx_q.size() == 0) obs = 32'hFFFF_FFFF;
        else obs = {24'd0, rx_q.pop_front()};
        chk(tag, obs, {24'd0, exp});
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] s;
        logic        sv;
        int          n;
        s = 32'h400;
        n = 0;
        while (s[10] && n < 400) begin
            csr(c_base, 1'b1, 3'd0, 32'd0, s, sv);
            n++;
        end
        chk(tag, {31'd0, s[10]}, 32'd0);
        repeat (3) idle();
    endtask

    logic [9:0] frame;

    initial begin
        errors = 0; checks = 0; frame_err = 0;
        mon_act = 1'b0; mon_cnt = 0; mon_sh = 8'd0;
        rstn = 1'b0; read = 1'b0; modify = 3'd0; wdata = 32'd0; addr = 12'd0;
        repeat (3) @(negedge clk);
        chk("reset_tx", {31'd0, tx}, 32'd1);
        rstn = 1'b1;
        repeat (50) idle();
        chk("idle_tx", {31'd0, tx}, 32'd1);
        chk("idle_valid", {31'd0, valid}, 32'd0);
        chk("idle_rdata", rdata, 32'd0);
        chk("idle_irq", {31'd0, irq}, 32'd0);
        csr(c_base, 1'b1, 3'd0, 32'd0, rd, v);
        chk("idle_read_valid", {31'd0, v}, 32'd1);
        chk("idle_read_status", rd, 32'd0);

        // Single byte 0x55: start, LSB first, stop.
        csr(c_base, 1'b0, 3'd1, 32'h55, rd, v);
        idle();
        chk("tx_before_start", {31'd0, tx}, 32'd1);
        frame = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 10 * c_div; i++) begin
            idle();
            chk($sformatf("tx_0x55_cycle%0d", i), {31'd0, tx}, {31'd0, frame[i / c_div]});
        end
        csr(c_base, 1'b1, 3'd0, 32'd0, rd, v);
        chk("after_0x55_status", rd, 32'd0);
        expect_rx("rx_0x55", 8'h55);

        // Non-matching address.
        csr(c_base + 12'd1, 1'b1, 3'd0, 32'd0, rd, v);
        chk("other_addr_valid", {31'd0, v}, 32'd0);
        chk("other_addr_rdata", rd, 32'd0);

        // Four writes: one pops straight away, three remain queued.
        csr(c_base, 1'b0, 3'd1, 32'h11, rd, v);
        csr(c_base, 1'b0, 3'd1, 32'h22, rd, v);
        csr(c_base, 1'b0, 3'd1, 32'h33, rd, v);
        csr(c_base, 1'b0, 3'd1, 32'h44, rd, v);
        csr(c_base, 1'b1, 3'd0, 32'd0, rd, v);
        chk("level3_valid", {31'd0, v}, 32'd1);
        chk("level3_status", rd, 32'h403);
        wait_idle("drain4");
        expect_rx("rx_0x11", 8'h11);
        expect_rx("rx_0x22", 8'h22);
        expect_rx("rx_0x33", 8'h33);
        expect_rx("rx_0x44", 8'h44);

        // Fill to full, overflow, SET is a no-op, CLEAR drops overflow.
        for (int i = 1; i <= 9; i++) csr(c_base, 1'b0, 3'd1, 32'(i), rd, v);
        csr(c_base, 1'b1, 3'd0, 32'd0, rd, v);
        chk("full_status", rd, 32'h508);
        csr(c_base, 1'b0, 3'd1, 32'hEE, rd, v);
        csr(c_base, 1'b1, 3'd0, 32'd0, rd, v);
        chk("overflow_status", rd, 32'h708);
        csr(c_base, 1'b0, 3'd2, 32'h0FF, rd, v);
        csr(c_base, 1'b1, 3'd0, 32'd0, rd, v);
        chk("set_noop_status", rd, 32'h708);
        csr(c_base, 1'b0, 3'd3, 32'h200, rd, v);
        csr(c_base, 1'b1, 3'd0, 32'd0, rd, v);
        chk("ovf_clear_status", rd, 32'h508);
        wait_idle("drain9");
        for (int i = 1; i <= 9; i++) expect_rx($sformatf("rx_fill_%0d", i), 8'(i));
        chk("no_extra_bytes", 32'(rx_q.size()), 32'd0);

        // Reset in the middle of data bit 3 of 0xA5 (bit 3 is low).
        csr(c_base, 1'b0, 3'd1, 32'hA5, rd, v);
        csr(c_base, 1'b0, 3'd1, 32'h12, rd, v);
        csr(c_base, 1'b0, 3'd1, 32'h34, rd, v);
        repeat (15) idle();
        chk("bit3_low", {31'd0, tx}, 32'd0);
        rstn = 1'b0;
        #1;
        chk("reset_tx_immediate", {31'd0, tx}, 32'd1);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        csr(c_base, 1'b1, 3'd0, 32'd0, rd, v);
        chk("post_reset_status", rd, 32'd0);
        repeat (100) idle();
        chk("post_reset_no_frame", 32'(rx_q.size()), 32'd0);
        chk("post_reset_tx", {31'd0, tx}, 32'd1);

`ifdef CSR_UART_IRQ_EN
        csr(c_base, 1'b0, 3'd2, 32'h800, rd, v);
        idle();
        idle();
        chk("irq_enabled_idle", {31'd0, irq}, 32'd1);
        csr(c_base, 1'b0, 3'd1, 32'h8A5, rd, v);
        csr(c_base, 1'b1, 3'd0, 32'd0, rd, v);
        chk("irq_frame_status", rd, 32'hC00);
        chk("irq_frame_start", {31'd0, irq}, 32'd0);
        repeat (39) idle();
        chk("irq_stop_last", {31'd0, irq}, 32'd0);
        idle();
        chk("irq_idle_first", {31'd0, irq}, 32'd0);
        idle();
        chk("irq_raised", {31'd0, irq}, 32'd1);
        expect_rx("rx_irq_0xA5", 8'hA5);
        csr(c_base, 1'b0, 3'd3, 32'h800, rd, v);
        idle();
        idle();
        chk("irq_cleared", {31'd0, irq}, 32'd0);
        csr(c_base, 1'b1, 3'd0, 32'd0, rd, v);
        chk("irq_en_cleared_status", rd, 32'd0);
`else
        csr(c_base, 1'b0, 3'd2, 32'h800, rd, v);
        csr(c_base, 1'b1, 3'd0, 32'd0, rd, v);
        chk("no_irq_en_bit", rd, 32'd0);
        repeat (3) idle();
        chk("irq_tied_low", {31'd0, irq}, 32'd0);
`endif

        chk("frame_errors", 32'(frame_err), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule : tb_csr_uart_tx
`default_nettype wire
